// File: rtl/ddr_burst_ctrl_if.sv
// ddr_burst_ctrl_if -- bundles the core-side request/response signals and the
// memory-side request/return signals of ddr_burst_ctrl.
//   slave  : the controller's view (accepts core requests, drives memory).
//   master : the environment's view (core issuing requests + memory model).
// Parameters: ADDR_W word-index width, BEATS 64-bit beats per burst line.
interface ddr_burst_ctrl_if #(
  parameter int ADDR_W = 19,
  parameter int BEATS  = 8
);
  // core side
  logic                    ddr_chip_enable;
  logic [ADDR_W-1:0]       ddr_index;
  logic                    ddr_write_enable;
  logic                    ddr_burst_mode;
  logic [63:0]             ddr_opstore_write_mask;
  logic [63:0]             ddr_opstore_write_data;
  logic [63:0]             ddr_opload_read_data;
  logic [64*BEATS-1:0]     ddr_pc_read_inst;
  logic                    ddr_operation_done;
  logic                    ddr_ready;
  logic                    ddr_error;
  // memory side
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_we;
  logic [63:0]             mem_wmask;
  logic [63:0]             mem_wdata;
  logic                    mem_rvalid;
  logic [63:0]             mem_rdata;

  modport slave (
    input  ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
           ddr_opstore_write_mask, ddr_opstore_write_data,
           mem_req_ready, mem_rvalid, mem_rdata,
    output ddr_opload_read_data, ddr_pc_read_inst, ddr_operation_done,
           ddr_ready, ddr_error,
           mem_req_valid, mem_addr, mem_we, mem_wmask, mem_wdata
  );

  modport master (
    output ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
           ddr_opstore_write_mask, ddr_opstore_write_data,
           mem_req_ready, mem_rvalid, mem_rdata,
    input  ddr_opload_read_data, ddr_pc_read_inst, ddr_operation_done,
           ddr_ready, ddr_error,
           mem_req_valid, mem_addr, mem_we, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/ddr_burst_ctrl.sv
// ddr_burst_ctrl -- single-outstanding DDR request controller.
// Accepts one core request at a time (single read, single write, or an
// 8-beat aligned instruction-line burst read) and sequences it onto a
// valid/ready memory request port with a separate rvalid read return.
// Ports:
//   clock  : sole clock, rising edge.
//   reset  : asynchronous, active-high.
//   bus    : ddr_burst_ctrl_if.slave (core request/response + memory port).
// Parameters: ADDR_W (word index width), BEATS (beats per line),
//   TIMEOUT_CYC (per-beat watchdog limit, only with DDR_TIMEOUT_EN).
// Optional feature: define DDR_TIMEOUT_EN to enable the per-beat watchdog,
// which substitutes 64'hDEAD_BEEF_DEAD_BEEF for a missing beat and sets the
// sticky ddr_error flag. Without it the block waits forever and ddr_error=0.
module ddr_burst_ctrl #(
  parameter int ADDR_W      = 19,
  parameter int BEATS       = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input logic             clock,
  input logic             reset,
  ddr_burst_ctrl_if.slave bus
);

  localparam int          BEAT_W   = $clog2(BEATS);
  localparam logic [63:0] TMO_FILL = 64'hDEAD_BEEF_DEAD_BEEF;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   req_index;
  logic                req_we;
  logic                req_burst;
  logic [63:0]         req_mask;
  logic [63:0]         req_data;
  logic [BEAT_W-1:0]   beat;
  logic [63:0]         opload_q;
  logic [64*BEATS-1:0] inst_q;

  logic                last_beat;
  logic                write_end;
  logic                beat_fill;
  logic [63:0]         fill_data;
  logic [ADDR_W-1:0]   beat_addr;
  logic                issue_tmo;
  logic                wait_tmo;
  logic                error_flag;

  // A write never bursts, so the burst flag is folded at latch time.
  assign last_beat = !req_burst || (beat == BEAT_W'(BEATS-1));

`ifdef DDR_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC+1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             error_q;

  // Fires in the TIMEOUT_CYC-th cycle spent on the current beat; a real
  // handshake/return in that same cycle takes priority.
  assign tmo_hit   = (state == ISSUE || state == WAIT) &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYC-1));
  assign issue_tmo = tmo_hit && (state == ISSUE) && !bus.mem_req_ready;
  assign wait_tmo  = tmo_hit && (state == WAIT)  && !bus.mem_rvalid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      tmo_cnt <= '0;
    else if ((state != ISSUE && state != WAIT) || beat_fill || write_end)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      error_q <= 1'b0;
    else if (issue_tmo || wait_tmo)
      error_q <= 1'b1;
  end

  assign error_flag = error_q;
`else
  assign issue_tmo  = 1'b0;
  assign wait_tmo   = 1'b0;
  assign error_flag = 1'b0;
`endif

  assign write_end = (state == ISSUE) && req_we && (bus.mem_req_ready || issue_tmo);
  // A read beat completes on a real return in WAIT, or on a watchdog expiry
  // in either WAIT or (never handshaken) ISSUE.
  assign beat_fill = ((state == WAIT) && (bus.mem_rvalid || wait_tmo)) ||
                     ((state == ISSUE) && !req_we && issue_tmo);
  assign fill_data = ((state == WAIT) && bus.mem_rvalid) ? bus.mem_rdata : TMO_FILL;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (bus.ddr_chip_enable) state_nx = ISSUE;
      ISSUE: begin
        if (write_end)
          state_nx = DONE;
        else if (bus.mem_req_ready)
          state_nx = WAIT;
        else if (beat_fill)
          state_nx = last_beat ? DONE : ISSUE;
      end
      WAIT:  if (beat_fill) state_nx = last_beat ? DONE : ISSUE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, beat counter and read result registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_index <= '0;
      req_we    <= 1'b0;
      req_burst <= 1'b0;
      req_mask  <= '0;
      req_data  <= '0;
      beat      <= '0;
      opload_q  <= '0;
      inst_q    <= '0;
    end else begin
      if (state == IDLE && bus.ddr_chip_enable) begin
        req_index <= bus.ddr_index;
        req_we    <= bus.ddr_write_enable;
        req_burst <= bus.ddr_burst_mode && !bus.ddr_write_enable;
        req_mask  <= bus.ddr_opstore_write_mask;
        req_data  <= bus.ddr_opstore_write_data;
        beat      <= '0;
      end
      if (beat_fill) begin
        if (!req_burst)
          opload_q <= fill_data;
        else
          for (int unsigned k = 0; k < BEATS; k++)
            if (beat == BEAT_W'(k)) inst_q[k*64 +: 64] <= fill_data;
        if (!last_beat)
          beat <= beat + 1'b1;
      end
    end
  end

  // Output logic
  always_comb begin
    beat_addr = req_index;
    if (req_burst)
      beat_addr = {req_index[ADDR_W-1:BEAT_W], {BEAT_W{1'b0}}} + ADDR_W'(beat);

    bus.ddr_ready            = (state == IDLE);
    bus.ddr_operation_done   = (state == DONE);
    bus.mem_req_valid        = (state == ISSUE);
    bus.mem_addr             = (state == ISSUE) ? beat_addr : '0;
    bus.mem_we               = (state == ISSUE) && req_we;
    bus.mem_wmask            = (state == ISSUE) ? req_mask : '0;
    bus.mem_wdata            = (state == ISSUE) ? req_data : '0;
    bus.ddr_opload_read_data = opload_q;
    bus.ddr_pc_read_inst     = inst_q;
    bus.ddr_error            = error_flag;
  end

endmodule

// File: tb/tb_ddr_burst_ctrl.sv
// tb_ddr_burst_ctrl -- self-checking bench for ddr_burst_ctrl.
// A behavioural memory (associative array with masked writes) answers the
// controller's requests; expected results are derived from that memory
// contents and the address/beat rules of the controller.
module tb_ddr_burst_ctrl;
  localparam int ADDR_W = 19;
  localparam int BEATS  = 8;
  localparam int TMO    = 255;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ddr_burst_ctrl_if #(.ADDR_W(ADDR_W), .BEATS(BEATS)) bus ();

  ddr_burst_ctrl #(.ADDR_W(ADDR_W), .BEATS(BEATS), .TIMEOUT_CYC(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // memory model and handshake log
  logic [63:0]       ref_mem [int unsigned];
  logic [ADDR_W-1:0] hs_addr [$];
  logic              hs_we   [$];
  logic [63:0]       hs_mask [$];
  logic [63:0]       hs_data [$];

  bit force_low  = 0;
  bit ready_rand = 0;
  bit lat_rand   = 0;
  bit no_resp    = 0;
  int fixed_delay = 0;
  bit pending = 0;
  logic [ADDR_W-1:0] pend_addr;
  int pend_delay = 0;

  logic [63:0]         exp_opload = '0;
  logic [64*BEATS-1:0] exp_inst   = '0;

  function automatic logic [63:0] mem_rd(input logic [ADDR_W-1:0] a);
    int unsigned key;
    key = a;
    if (ref_mem.exists(key)) return ref_mem[key];
    return {32'(a) ^ 32'hA5A5_0F0F, 32'(a) * 32'h9E37_79B9};
  endfunction

  function automatic void clear_log();
    hs_addr.delete(); hs_we.delete(); hs_mask.delete(); hs_data.delete();
  endfunction

  // Expected read results: single -> the word itself; burst -> the 8 words of
  // the aligned line, beat k in bits [64k+63:64k].
  function automatic void model_read(input logic [ADDR_W-1:0] idx, input bit burst);
    logic [ADDR_W-1:0] base;
    base = idx;
    base[2:0] = 3'b000;
    if (!burst) exp_opload = mem_rd(idx);
    else for (int k = 0; k < BEATS; k++) exp_inst[k*64 +: 64] = mem_rd(base + ADDR_W'(k));
  endfunction

  // Number of discrepancies between the logged memory requests and the
  // request sequence the operation should produce.
  function automatic int hs_bad(input logic [ADDR_W-1:0] idx, input logic we,
                                input logic burst, input logic [63:0] mask,
                                input logic [63:0] data);
    int n;
    int bad;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] a;
    n = (we || !burst) ? 1 : BEATS;
    bad = 0;
    base = idx;
    base[2:0] = 3'b000;
    if (hs_addr.size() != n) return 1000 + hs_addr.size();
    for (int k = 0; k < n; k++) begin
      a = (we || !burst) ? idx : base + ADDR_W'(k);
      if (hs_addr[k] !== a || hs_we[k] !== we) bad++;
      if (we && (hs_mask[k] !== mask || hs_data[k] !== data)) bad++;
    end
    return bad;
  endfunction

  // Memory responder: decides ready and read returns at each falling edge.
  initial begin
    bus.mem_req_ready = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = '0;
    forever begin
      @(negedge clock);
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = {$urandom, $urandom};
      if (pending) begin
        if (pend_delay == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = mem_rd(pend_addr);
          pending = 0;
        end else pend_delay--;
      end
      if (force_low)       bus.mem_req_ready = 1'b0;
      else if (ready_rand) bus.mem_req_ready = ($urandom_range(0, 2) != 0);
      else                 bus.mem_req_ready = 1'b1;
      if (bus.mem_req_valid && bus.mem_req_ready && !reset) begin
        hs_addr.push_back(bus.mem_addr);
        hs_we.push_back(bus.mem_we);
        hs_mask.push_back(bus.mem_wmask);
        hs_data.push_back(bus.mem_wdata);
        if (bus.mem_we) begin
          int unsigned key;
          key = bus.mem_addr;
          ref_mem[key] = (mem_rd(bus.mem_addr) & ~bus.mem_wmask) | (bus.mem_wdata & bus.mem_wmask);
        end else if (!no_resp) begin
          pending    = 1;
          pend_addr  = bus.mem_addr;
          pend_delay = lat_rand ? int'($urandom_range(0, 3)) : fixed_delay;
        end
      end
    end
  end

  // Issue one request and wait (bounded) for its done pulse. lat counts
  // falling edges after the strobe edge (1 = first cycle after the strobe).
  task automatic do_req(input logic [ADDR_W-1:0] idx, input logic we, input logic burst,
                        input logic [63:0] mask, input logic [63:0] data,
                        output int lat, output bit got_done, output bit ready_low,
                        output bit one_pulse);
    @(negedge clock);
    bus.ddr_chip_enable        = 1'b1;
    bus.ddr_index              = idx;
    bus.ddr_write_enable       = we;
    bus.ddr_burst_mode         = burst;
    bus.ddr_opstore_write_mask = mask;
    bus.ddr_opstore_write_data = data;
    @(negedge clock);
    bus.ddr_chip_enable        = 1'b0;
    bus.ddr_index              = ADDR_W'($urandom);
    bus.ddr_write_enable       = 1'($urandom_range(0, 1));
    bus.ddr_burst_mode         = 1'($urandom_range(0, 1));
    bus.ddr_opstore_write_mask = {$urandom, $urandom};
    bus.ddr_opstore_write_data = {$urandom, $urandom};
    lat = 1; got_done = 0; ready_low = 1; one_pulse = 0;
    while (lat < 2000) begin
      if (bus.ddr_operation_done === 1'b1) begin got_done = 1; break; end
      if (bus.ddr_ready !== 1'b0) ready_low = 0;
      @(negedge clock);
      lat++;
    end
    if (got_done) begin
      @(negedge clock);
      one_pulse = (bus.ddr_operation_done === 1'b0) && (bus.ddr_ready === 1'b1);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.ddr_chip_enable = 1'b1;
    @(negedge clock);
    n_checks++; if (bus.ddr_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.ddr_ready); else n_pass++;
    n_checks++; if (bus.ddr_operation_done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.ddr_operation_done); else n_pass++;
    n_checks++; if ({bus.mem_req_valid, bus.mem_we, bus.mem_addr, bus.mem_wmask, bus.mem_wdata} !== '0)
      $display("FAIL reset_mem: valid %b we %b addr %h mask %h data %h want all 0", bus.mem_req_valid, bus.mem_we, bus.mem_addr, bus.mem_wmask, bus.mem_wdata);
    else n_pass++;
    n_checks++; if (bus.ddr_opload_read_data !== 64'h0) $display("FAIL reset_opload: got %h want 0", bus.ddr_opload_read_data); else n_pass++;
    n_checks++; if (bus.ddr_pc_read_inst !== '0) $display("FAIL reset_inst: got nonzero %h", bus.ddr_pc_read_inst[63:0]); else n_pass++;
    n_checks++; if (bus.ddr_error !== 1'b0) $display("FAIL reset_error: got %b want 0", bus.ddr_error); else n_pass++;
    bus.ddr_chip_enable = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    int lat; bit gd, rl, op;
    ref_mem[32'h10] = 64'h1122_3344_5566_7788;
    clear_log();
    model_read(19'h00010, 0);
    do_req(19'h00010, 1'b0, 1'b0, 64'hFFFF, 64'h1234, lat, gd, rl, op);
    n_checks++; if (lat !== 3) $display("FAIL single_latency: got %0d want 3", lat); else n_pass++;
    n_checks++; if (hs_bad(19'h00010, 1'b0, 1'b0, '0, '0) !== 0) $display("FAIL single_req: %0d request errors, want 0", hs_bad(19'h00010, 1'b0, 1'b0, '0, '0)); else n_pass++;
    n_checks++; if (bus.ddr_opload_read_data !== 64'h1122_3344_5566_7788) $display("FAIL single_data: got %h want 1122334455667788", bus.ddr_opload_read_data); else n_pass++;
    n_checks++; if (op !== 1'b1) $display("FAIL single_done_pulse: got %b want 1 (one cycle, ready after)", op); else n_pass++;
    n_checks++; if (rl !== 1'b1) $display("FAIL single_busy_ready: got %b want 1 (ready low while busy)", rl); else n_pass++;
    n_checks++; if (bus.ddr_pc_read_inst !== exp_inst) $display("FAIL single_inst_hold: got %h want %h", bus.ddr_pc_read_inst[63:0], exp_inst[63:0]); else n_pass++;
  endtask

  task automatic test_write();
    int lat; bit gd, rl, op;
    clear_log();
    do_req(19'h7FFFF, 1'b1, 1'b0, 64'hFF, 64'hAB, lat, gd, rl, op);
    n_checks++; if (lat !== 2) $display("FAIL write_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (hs_bad(19'h7FFFF, 1'b1, 1'b0, 64'hFF, 64'hAB) !== 0) $display("FAIL write_req: %0d request errors, want 0", hs_bad(19'h7FFFF, 1'b1, 1'b0, 64'hFF, 64'hAB)); else n_pass++;
    n_checks++; if (op !== 1'b1) $display("FAIL write_done_pulse: got %b want 1", op); else n_pass++;
    n_checks++; if (bus.ddr_opload_read_data !== exp_opload) $display("FAIL write_opload_hold: got %h want %h", bus.ddr_opload_read_data, exp_opload); else n_pass++;
    // burst-mode write is a single write
    clear_log();
    do_req(19'h00021, 1'b1, 1'b1, 64'hF0F0, 64'h5555_AAAA, lat, gd, rl, op);
    n_checks++; if (lat !== 2) $display("FAIL burstwrite_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (hs_bad(19'h00021, 1'b1, 1'b1, 64'hF0F0, 64'h5555_AAAA) !== 0) $display("FAIL burstwrite_req: %0d request errors, want 0", hs_bad(19'h00021, 1'b1, 1'b1, 64'hF0F0, 64'h5555_AAAA)); else n_pass++;
  endtask

  task automatic test_burst();
    int lat; bit gd, rl, op;
    for (int k = 0; k < BEATS; k++) ref_mem[8 + k] = 64'(k + 1);
    clear_log();
    model_read(19'h0000D, 1);
    do_req(19'h0000D, 1'b0, 1'b1, '0, '0, lat, gd, rl, op);
    n_checks++; if (lat !== 1 + 2*BEATS) $display("FAIL burst_latency: got %0d want %0d", lat, 1 + 2*BEATS); else n_pass++;
    n_checks++; if (hs_bad(19'h0000D, 1'b0, 1'b1, '0, '0) !== 0) $display("FAIL burst_addrs: %0d request errors, want 0", hs_bad(19'h0000D, 1'b0, 1'b1, '0, '0)); else n_pass++;
    n_checks++; if (bus.ddr_pc_read_inst[63:0] !== 64'd1) $display("FAIL burst_beat0: got %h want 1", bus.ddr_pc_read_inst[63:0]); else n_pass++;
    n_checks++; if (bus.ddr_pc_read_inst[511:448] !== 64'd8) $display("FAIL burst_beat7: got %h want 8", bus.ddr_pc_read_inst[511:448]); else n_pass++;
    n_checks++; if (bus.ddr_pc_read_inst !== exp_inst) $display("FAIL burst_line: got %h want %h", bus.ddr_pc_read_inst, exp_inst); else n_pass++;
    n_checks++; if (op !== 1'b1) $display("FAIL burst_done_pulse: got %b want 1", op); else n_pass++;
    n_checks++; if (bus.ddr_opload_read_data !== exp_opload) $display("FAIL burst_opload_hold: got %h want %h", bus.ddr_opload_read_data, exp_opload); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] snap_addr;
    bit stable, ready_ok, gd;
    int cnt;
    clear_log();
    model_read(19'h00123, 0);
    force_low = 1;
    @(negedge clock);
    bus.ddr_chip_enable  = 1'b1;
    bus.ddr_index        = 19'h00123;
    bus.ddr_write_enable = 1'b0;
    bus.ddr_burst_mode   = 1'b0;
    @(negedge clock);
    bus.ddr_chip_enable = 1'b0;
    snap_addr = bus.mem_addr;
    stable = 1; ready_ok = 1; gd = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== snap_addr || bus.mem_we !== 1'b0) stable = 0;
      if (bus.ddr_ready !== 1'b0) ready_ok = 0;
      if (i == 1) begin
        bus.ddr_chip_enable  = 1'b1;
        bus.ddr_index        = 19'h00456;
        bus.ddr_write_enable = 1'b1;
      end else bus.ddr_chip_enable = 1'b0;
      if (i == 4) force_low = 0;
      @(negedge clock);
    end
    cnt = 0;
    while (cnt < 50) begin
      if (bus.ddr_operation_done === 1'b1) begin gd = 1; break; end
      if (bus.ddr_ready !== 1'b0) ready_ok = 0;
      @(negedge clock);
      cnt++;
    end
    n_checks++; if (snap_addr !== 19'h00123 || stable !== 1'b1) $display("FAIL bp_stable: addr %h stable %b want 00123/1", snap_addr, stable); else n_pass++;
    n_checks++; if (ready_ok !== 1'b1) $display("FAIL bp_ready_low: got %b want 1", ready_ok); else n_pass++;
    n_checks++; if (gd !== 1'b1) $display("FAIL bp_done: got %b want 1 within budget", gd); else n_pass++;
    n_checks++; if (bus.ddr_opload_read_data !== exp_opload) $display("FAIL bp_data: got %h want %h", bus.ddr_opload_read_data, exp_opload); else n_pass++;
    repeat (4) @(negedge clock);
    n_checks++; if (hs_bad(19'h00123, 1'b0, 1'b0, '0, '0) !== 0) $display("FAIL bp_second_ignored: %0d request errors, want 0", hs_bad(19'h00123, 1'b0, 1'b0, '0, '0)); else n_pass++;
    n_checks++; if (bus.ddr_ready !== 1'b1) $display("FAIL bp_idle_ready: got %b want 1", bus.ddr_ready); else n_pass++;
  endtask

  task automatic test_reset_midop();
    int cnt;
    bit saw_done, bad_idle;
    clear_log();
    fixed_delay = 6;
    @(negedge clock);
    bus.ddr_chip_enable  = 1'b1;
    bus.ddr_index        = 19'h00040;
    bus.ddr_write_enable = 1'b0;
    bus.ddr_burst_mode   = 1'b1;
    @(negedge clock);
    bus.ddr_chip_enable = 1'b0;
    cnt = 0;
    while (hs_addr.size() < 4 && cnt < 200) begin @(negedge clock); cnt++; end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    fixed_delay = 0;
    exp_opload = '0;
    exp_inst   = '0;
    saw_done = 0; bad_idle = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.ddr_operation_done !== 1'b0) saw_done = 1;
      if (bus.ddr_ready !== 1'b1 || bus.mem_req_valid !== 1'b0) bad_idle = 1;
    end
    n_checks++; if (cnt >= 200) $display("FAIL rst_reach_beat3: got %0d requests want 4", hs_addr.size()); else n_pass++;
    n_checks++; if (saw_done !== 1'b0) $display("FAIL rst_no_done: got %b want 0", saw_done); else n_pass++;
    n_checks++; if (bad_idle !== 1'b0) $display("FAIL rst_idle: got bad=%b want 0 (ready=1, valid=0)", bad_idle); else n_pass++;
    n_checks++; if (bus.ddr_opload_read_data !== 64'h0 || bus.ddr_pc_read_inst !== '0)
      $display("FAIL rst_outputs_zero: opload %h inst[63:0] %h want 0", bus.ddr_opload_read_data, bus.ddr_pc_read_inst[63:0]);
    else n_pass++;
    n_checks++; if (hs_addr.size() !== 4) $display("FAIL rst_no_new_req: got %0d requests want 4", hs_addr.size()); else n_pass++;
  endtask

  task automatic test_random();
    int lat; bit gd, rl, op;
    logic [ADDR_W-1:0] idx;
    logic we, burst;
    logic [63:0] mask, data;
    ready_rand = 1;
    lat_rand   = 1;
    for (int t = 0; t < 40; t++) begin
      idx   = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 47));
      we    = ($urandom_range(0, 2) == 0);
      burst = 1'($urandom_range(0, 1));
      mask  = {$urandom, $urandom};
      data  = {$urandom, $urandom};
      clear_log();
      if (!we) model_read(idx, burst);
      do_req(idx, we, burst, mask, data, lat, gd, rl, op);
      n_checks++; if (gd !== 1'b1) $display("FAIL rnd%0d_done: got %b want 1 within budget", t, gd); else n_pass++;
      n_checks++; if (op !== 1'b1) $display("FAIL rnd%0d_pulse: got %b want 1", t, op); else n_pass++;
      n_checks++; if (rl !== 1'b1) $display("FAIL rnd%0d_busy_ready: got %b want 1", t, rl); else n_pass++;
      n_checks++; if (hs_bad(idx, we, burst, mask, data) !== 0) $display("FAIL rnd%0d_req: %0d request errors want 0 (idx %h we %b burst %b)", t, hs_bad(idx, we, burst, mask, data), idx, we, burst); else n_pass++;
      n_checks++; if (bus.ddr_opload_read_data !== exp_opload) $display("FAIL rnd%0d_opload: got %h want %h", t, bus.ddr_opload_read_data, exp_opload); else n_pass++;
      n_checks++; if (bus.ddr_pc_read_inst !== exp_inst) $display("FAIL rnd%0d_inst: got %h want %h", t, bus.ddr_pc_read_inst, exp_inst); else n_pass++;
    end
    ready_rand = 0;
    lat_rand   = 0;
    n_checks++; if (bus.ddr_error !== 1'b0) $display("FAIL rnd_error: got %b want 0", bus.ddr_error); else n_pass++;
  endtask

`ifdef DDR_TIMEOUT_EN
  task automatic test_timeout();
    int lat; bit gd, rl, op;
    no_resp = 1;
    do_req(19'h00055, 1'b0, 1'b0, '0, '0, lat, gd, rl, op);
    no_resp = 0;
    n_checks++; if (lat !== TMO + 1) $display("FAIL tmo_latency: got %0d want %0d", lat, TMO + 1); else n_pass++;
    n_checks++; if (bus.ddr_opload_read_data !== 64'hDEAD_BEEF_DEAD_BEEF) $display("FAIL tmo_fill: got %h want deadbeefdeadbeef", bus.ddr_opload_read_data); else n_pass++;
    n_checks++; if (bus.ddr_error !== 1'b1) $display("FAIL tmo_error: got %b want 1", bus.ddr_error); else n_pass++;
    n_checks++; if (op !== 1'b1) $display("FAIL tmo_pulse: got %b want 1", op); else n_pass++;
    model_read(19'h00056, 0);
    do_req(19'h00056, 1'b0, 1'b0, '0, '0, lat, gd, rl, op);
    n_checks++; if (bus.ddr_error !== 1'b1) $display("FAIL tmo_sticky: got %b want 1", bus.ddr_error); else n_pass++;
    n_checks++; if (bus.ddr_opload_read_data !== exp_opload) $display("FAIL tmo_recover: got %h want %h", bus.ddr_opload_read_data, exp_opload); else n_pass++;
  endtask
`endif

  initial begin
    bus.ddr_chip_enable        = 1'b0;
    bus.ddr_index              = '0;
    bus.ddr_write_enable       = 1'b0;
    bus.ddr_burst_mode         = 1'b0;
    bus.ddr_opstore_write_mask = '0;
    bus.ddr_opstore_write_data = '0;
    test_reset();
    test_single_read();
    test_write();
    test_burst();
    test_backpressure();
    test_reset_midop();
    test_random();
`ifdef DDR_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_checks);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ddr_burst_ctrl.md
DDR_BURST_CTRL -- requirements
Module: ddr_burst_ctrl

Interface
REQ-001 Parameter ADDR_W, default 19: width of the 64-bit-word index on both sides.
REQ-002 Parameter BEATS, default 8: number of 64-bit beats per burst; fixed by the 512-bit instruction line.
REQ-003 Parameter TIMEOUT_CYC, default 255: watchdog limit in cycles; used only with DDR_TIMEOUT_EN.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ddr_chip_enable  in  1  core request strobe, one cycle.
REQ-007 ddr_index  in  ADDR_W  word index of the request.
REQ-008 ddr_write_enable  in  1  1 = write, 0 = read.
REQ-009 ddr_burst_mode  in  1  1 = 8-beat instruction-line read.
REQ-010 ddr_opstore_write_mask  in  64  bit-level write mask.
REQ-011 ddr_opstore_write_data  in  64  write data.
REQ-012 ddr_opload_read_data  out  64  single-read result.
REQ-013 ddr_pc_read_inst  out  512  burst-read result.
REQ-014 ddr_operation_done  out  1  one-cycle completion pulse.
REQ-015 ddr_ready  out  1  controller can accept a request.
REQ-016 mem_req_valid / mem_req_ready  out/in  1/1  memory request handshake.
REQ-017 mem_addr  out  ADDR_W  memory word address.
REQ-018 mem_we  out  1  memory write strobe.
REQ-019 mem_wmask, mem_wdata  out  64 each  memory write mask and data.
REQ-020 mem_rvalid, mem_rdata  in  1/64  memory read return.
REQ-021 ddr_error  out  1  sticky timeout flag.

Function
REQ-022 The block SHALL implement states IDLE, ISSUE, WAIT and DONE.
REQ-023 ddr_ready SHALL be 1 only in IDLE.
REQ-024 In IDLE, ddr_chip_enable=1 SHALL latch index, write_enable, burst_mode, mask and data, and move to ISSUE.
REQ-025 ddr_chip_enable SHALL be ignored in all states other than IDLE.
REQ-026 In ISSUE, mem_req_valid SHALL be 1, with mem_addr, mem_we, mem_wmask and mem_wdata driven from the latched request.
REQ-027 All mem_* outputs SHALL hold stable until mem_req_valid && mem_req_ready.
REQ-028 Write: on handshake, the block SHALL go to DONE.
REQ-029 Read: on handshake, the block SHALL go to WAIT.
REQ-030 Write with ddr_burst_mode=1 SHALL be treated as a single write.
REQ-031 In WAIT, mem_rvalid SHALL store mem_rdata.
REQ-032 Single read: mem_rdata SHALL go to ddr_opload_read_data, then DONE.
REQ-033 Burst read: beat k SHALL go to ddr_pc_read_inst[64k+63:64k].
REQ-034 Burst read: after beat k<7 the block SHALL return to ISSUE with beat k+1; after beat 7, DONE.
REQ-035 mem_rvalid SHALL be ignored outside WAIT.
REQ-036 Only one memory request SHALL be outstanding at a time.
REQ-037 Burst base address SHALL be {ddr_index[ADDR_W-1:3],3'b000}; beat address = base+k, so bursts never cross an 8-word line.
REQ-038 In DONE, ddr_operation_done SHALL be 1 for exactly one cycle, then IDLE.
REQ-039 Read result outputs SHALL hold their value until overwritten by a later read beat.
REQ-040 Minimum latency SHALL be: single op, strobe at t0 -> done at t3 (with ready and rvalid zero-wait); burst -> done at t0+1+2*8.

Reset
REQ-041 Reset SHALL force state=IDLE, beat counter=0, all outputs 0 except ddr_ready=1.
REQ-042 Reset mid-operation SHALL abandon the request with no done pulse; any late mem_rvalid SHALL be ignored.

Configuration
REQ-043 With macro DDR_TIMEOUT_EN defined, a counter SHALL count cycles spent in ISSUE+WAIT for the current beat.
REQ-044 With DDR_TIMEOUT_EN, reaching TIMEOUT_CYC SHALL: load the beat with 64'hDEAD_BEEF_DEAD_BEEF, set ddr_error (cleared only by reset), and continue as if the beat returned.
REQ-045 Without DDR_TIMEOUT_EN, the block SHALL wait indefinitely, and ddr_error SHALL be tied 0.

Verification
REQ-046 Single read: index=0x00010, mem ready, rvalid one cycle after handshake with data 0x1122334455667788 -> mem_addr=0x00010, opload_read_data=0x1122334455667788, done pulse at t3, ready=1 at t4.
REQ-047 Write: index=0x7FFFF, mask=0xFF, data=0xAB -> mem_we=1, mem_addr=0x7FFFF, wmask=0xFF, done at t2+ready wait, no rvalid needed.
REQ-048 Burst: index=0x0000D, beat k returns data k+1 -> addresses 0x08..0x0F in order, pc_read_inst[63:0]=1, [511:448]=8, single done pulse.
REQ-049 Backpressure: mem_req_ready low 5 cycles, strobe also asserted during busy -> mem_* stable; second strobe ignored; ready=0 until done.
REQ-050 Reset asserted in WAIT of beat 3, then a stale rvalid -> IDLE, ready=1, no done pulse, outputs 0.
REQ-051 DDR_TIMEOUT_EN: rvalid never returned on a single read -> after 255 cycles, opload_read_data=0xDEADBEEFDEADBEEF, ddr_error=1, done pulse.
